// File: rtl/reg8.sv
// Loadable register with priority rst > set > we > hold, a one-cycle change pulse,
// and an optional registered even-parity output enabled by defining REG8_PARITY_EN.
module reg8 #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] SET_VAL   = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set,
    input  logic [WIDTH-1:0] wdata,
    input  logic             we,
    output logic [WIDTH-1:0] rdata,
`ifdef REG8_PARITY_EN
    output logic             rpar,
`endif
    output logic             changed
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;
    logic             changed_q;

    // rst is folded in here too so value_d is the true next state.
    always_comb begin
        value_d = value_q;
        if (rst)
            value_d = RESET_VAL;
        else if (set)
            value_d = SET_VAL;
        else if (we)
            value_d = wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q   <= RESET_VAL;
            changed_q <= 1'b0;
        end else begin
            value_q   <= value_d;
            changed_q <= (value_d != value_q);
        end
    end

`ifdef REG8_PARITY_EN
    logic rpar_q;

    // Registered from the next value so it tracks rdata with no combinational path.
    always_ff @(posedge clk) begin
        if (rst)
            rpar_q <= ^RESET_VAL;
        else
            rpar_q <= ^value_d;
    end

    assign rpar = rpar_q;
`endif

    assign rdata   = value_q;
    assign changed = changed_q;

endmodule

// File: tb/tb_reg8.sv
// Self-checking bench for reg8: directed scenarios plus randomized traffic
// checked against a priority-rule shadow model.
module tb_reg8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       set = 1'b0;
    logic       we  = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata;
    logic       changed;
`ifdef REG8_PARITY_EN
    logic       rpar;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] m_val;
    logic       m_chg;

    always #5 clk = ~clk;

    reg8 dut (
        .clk     (clk),
        .rst     (rst),
        .set     (set),
        .wdata   (wdata),
        .we      (we),
        .rdata   (rdata),
`ifdef REG8_PARITY_EN
        .rpar    (rpar),
`endif
        .changed (changed)
    );

    // Drive one edge's worth of inputs and advance the shadow model.
    task automatic cycle(input logic r, input logic s, input logic w, input logic [7:0] d);
        logic [7:0] nv;
        @(negedge clk);
        rst = r; set = s; we = w; wdata = d;
        @(posedge clk);
        if (r)      nv = 8'h00;
        else if (s) nv = 8'hFF;
        else if (w) nv = d;
        else        nv = m_val;
        m_chg = !r && (nv != m_val);
        m_val = nv;
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b0, 1'b0, 8'h3C);
        n_cmp++; if (rdata !== 8'h00) begin n_bad++; $display("FAIL reset_rdata got %h want 00", rdata); end
        n_cmp++; if (changed !== 1'b0) begin n_bad++; $display("FAIL reset_changed got %b want 0", changed); end
`ifdef REG8_PARITY_EN
        n_cmp++; if (rpar !== 1'b0) begin n_bad++; $display("FAIL reset_rpar got %b want 0", rpar); end
`endif
        cycle(1'b0, 1'b0, 1'b0, 8'hC3);
        n_cmp++; if (rdata !== 8'h00) begin n_bad++; $display("FAIL reset_release got %h want 00", rdata); end
    endtask

    task automatic test_write();
        cycle(1'b0, 1'b0, 1'b1, 8'hAA);
        n_cmp++; if (rdata !== 8'hAA) begin n_bad++; $display("FAIL write_rdata got %h want AA", rdata); end
        n_cmp++; if (changed !== 1'b1) begin n_bad++; $display("FAIL write_changed got %b want 1", changed); end
        cycle(1'b0, 1'b0, 1'b0, 8'hAA);
        n_cmp++; if (changed !== 1'b0) begin n_bad++; $display("FAIL write_pulse got %b want 0", changed); end
        cycle(1'b0, 1'b0, 1'b1, 8'hAA);
        n_cmp++; if (changed !== 1'b0) begin n_bad++; $display("FAIL write_same got %b want 0", changed); end
    endtask

    task automatic test_hold();
        cycle(1'b0, 1'b0, 1'b0, 8'h55);
        n_cmp++; if (rdata !== 8'hAA) begin n_bad++; $display("FAIL hold_rdata got %h want AA", rdata); end
        n_cmp++; if (changed !== 1'b0) begin n_bad++; $display("FAIL hold_changed got %b want 0", changed); end
    endtask

    task automatic test_set();
        cycle(1'b0, 1'b1, 1'b1, 8'h12);
        n_cmp++; if (rdata !== 8'hFF) begin n_bad++; $display("FAIL set_rdata got %h want FF", rdata); end
        n_cmp++; if (changed !== 1'b1) begin n_bad++; $display("FAIL set_changed got %b want 1", changed); end
        cycle(1'b0, 1'b1, 1'b0, 8'h12);
        n_cmp++; if (changed !== 1'b0) begin n_bad++; $display("FAIL set_repeat got %b want 0", changed); end
        cycle(1'b0, 1'b0, 1'b0, 8'h12);
        n_cmp++; if (rdata !== 8'hFF) begin n_bad++; $display("FAIL set_hold got %h want FF", rdata); end
    endtask

    task automatic test_priority();
        cycle(1'b1, 1'b1, 1'b0, 8'h00);
        n_cmp++; if (rdata !== 8'h00) begin n_bad++; $display("FAIL prio_rst_set got %h want 00", rdata); end
        n_cmp++; if (changed !== 1'b0) begin n_bad++; $display("FAIL prio_rst_changed got %b want 0", changed); end
        cycle(1'b0, 1'b0, 1'b1, 8'h07);
        n_cmp++; if (rdata !== 8'h07) begin n_bad++; $display("FAIL prio_write07 got %h want 07", rdata); end
`ifdef REG8_PARITY_EN
        n_cmp++; if (rpar !== 1'b1) begin n_bad++; $display("FAIL prio_rpar got %b want 1", rpar); end
`endif
        cycle(1'b1, 1'b0, 1'b1, 8'h5A);
        n_cmp++; if (rdata !== 8'h00) begin n_bad++; $display("FAIL prio_rst_we got %h want 00", rdata); end
        n_cmp++; if (changed !== 1'b0) begin n_bad++; $display("FAIL prio_rst_we_chg got %b want 0", changed); end
    endtask

    task automatic test_random();
        logic r, s, w;
        for (int i = 0; i < 1000; i++) begin
            r = ($urandom_range(0, 19) == 0);
            s = ($urandom_range(0, 9) == 0);
            w = $urandom_range(0, 1) == 1;
            cycle(r, s, w, 8'($urandom));
            n_cmp++;
            if (rdata !== m_val) begin
                n_bad++; $display("FAIL rand_rdata cyc %0d got %h want %h", i, rdata, m_val);
            end
            n_cmp++;
            if (changed !== m_chg) begin
                n_bad++; $display("FAIL rand_changed cyc %0d got %b want %b", i, changed, m_chg);
            end
`ifdef REG8_PARITY_EN
            n_cmp++;
            if (rpar !== ^m_val) begin
                n_bad++; $display("FAIL rand_rpar cyc %0d got %b want %b", i, rpar, ^m_val);
            end
`endif
        end
    endtask

    initial begin
        m_val = 8'hxx;
        m_chg = 1'b0;
        test_reset();
        test_write();
        test_hold();
        test_set();
        test_priority();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
